// File: rtl/pu_riscv_biu_arbiter_if.sv
// One BIU request/response port; the requester drives the master side, the arbiter/bridge side is slave.
// btype carries the AHB-style burst type (SINGLE, INCR, WRAP4 .. INCR16).
interface pu_riscv_biu_arbiter_if #(
  parameter int XLEN = 64,
  parameter int PLEN = 64
);
  logic            stb;
  logic [PLEN-1:0] adri;
  logic [2:0]      size;
  logic [2:0]      btype;
  logic [2:0]      prot;
  logic            lock;
  logic            we;
  logic [XLEN-1:0] d;
  logic            stb_ack;
  logic            d_ack;
  logic            ack;
  logic            err;
  logic [XLEN-1:0] q;
  logic [PLEN-1:0] adro;

  modport master (
    output stb, adri, size, btype, prot, lock, we, d,
    input  stb_ack, d_ack, ack, err, q, adro
  );

  modport slave (
    input  stb, adri, size, btype, prot, lock, we, d,
    output stb_ack, d_ack, ack, err, q, adro
  );
endinterface

// File: rtl/pu_riscv_biu_arbiter.sv
// Round-robin, lock-aware arbiter sharing one BIU port between fetch (m0) and data (m1) requesters.
// Request reaches the bridge one cycle after stb; one transaction outstanding, responses routed to owner only.
module pu_riscv_biu_arbiter #(
  parameter int XLEN = 64,
  parameter int PLEN = 64
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  pu_riscv_biu_arbiter_if.slave  m0,
  pu_riscv_biu_arbiter_if.slave  m1,
  pu_riscv_biu_arbiter_if.master biu
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t          st;
  logic            owner;
  logic            last;
  logic            locked;
  logic [4:0]      beats;

  logic [PLEN-1:0] own_adri;
  logic [2:0]      own_size;
  logic [2:0]      own_btype;
  logic [2:0]      own_prot;
  logic            own_lock;
  logic            own_we;
  logic [XLEN-1:0] own_d;
  logic            own_stb;
  logic [4:0]      own_len;
  logic            in_addr;
  logic            in_xfer;

  function automatic logic [4:0] burst_len(input logic [2:0] t);
    case (t)
      3'd2, 3'd3: burst_len = 5'd4;
      3'd4, 3'd5: burst_len = 5'd8;
      3'd6, 3'd7: burst_len = 5'd16;
      default:    burst_len = 5'd1;
    endcase
  endfunction

  assign own_adri  = owner ? m1.adri  : m0.adri;
  assign own_size  = owner ? m1.size  : m0.size;
  assign own_btype = owner ? m1.btype : m0.btype;
  assign own_prot  = owner ? m1.prot  : m0.prot;
  assign own_lock  = owner ? m1.lock  : m0.lock;
  assign own_we    = owner ? m1.we    : m0.we;
  assign own_d     = owner ? m1.d     : m0.d;
  assign own_stb   = owner ? m1.stb   : m0.stb;
  assign own_len   = burst_len(own_btype);

  assign in_addr = (st == ADDR);
  assign in_xfer = (st == ADDR) || (st == DATA);

  // Address-phase fields only exist in ADDR; write data and direction persist through DATA.
  assign biu.stb   = in_addr;
  assign biu.adri  = in_addr ? own_adri  : '0;
  assign biu.size  = in_addr ? own_size  : 3'd0;
  assign biu.btype = in_addr ? own_btype : 3'd0;
  assign biu.prot  = in_addr ? own_prot  : 3'd0;
  assign biu.lock  = in_addr ? own_lock  : 1'b0;
  assign biu.we    = in_xfer ? own_we    : 1'b0;
  assign biu.d     = in_xfer ? own_d     : '0;

  assign m0.stb_ack = biu.stb_ack & in_addr & ~owner;
  assign m0.d_ack   = biu.d_ack   & in_xfer & ~owner;
  assign m0.ack     = biu.ack     & in_xfer & ~owner;
  assign m0.err     = biu.err     & in_xfer & ~owner;
  assign m0.q       = biu.q;
  assign m0.adro    = biu.adro;

  assign m1.stb_ack = biu.stb_ack & in_addr & owner;
  assign m1.d_ack   = biu.d_ack   & in_xfer & owner;
  assign m1.ack     = biu.ack     & in_xfer & owner;
  assign m1.err     = biu.err     & in_xfer & owner;
  assign m1.q       = biu.q;
  assign m1.adro    = biu.adro;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      st     <= IDLE;
      owner  <= 1'b0;
      last   <= 1'b1;
      locked <= 1'b0;
      beats  <= 5'd0;
    end else begin
      case (st)
        IDLE: begin
          if (locked && own_stb) begin
            st <= ADDR;
          end else if (m0.stb && m1.stb) begin
            owner <= ~last;
            st    <= ADDR;
          end else if (m0.stb) begin
            owner <= 1'b0;
            st    <= ADDR;
          end else if (m1.stb) begin
            owner <= 1'b1;
            st    <= ADDR;
          end
        end
        ADDR: begin
          // An accepted request moves the round-robin pointer even if it errors out.
          if (biu.stb_ack) begin
            last   <= owner;
            locked <= own_lock;
          end
          if (biu.err) begin
            st     <= IDLE;
            locked <= 1'b0;
            beats  <= 5'd0;
          end else if (biu.stb_ack) begin
            if (biu.ack && own_len == 5'd1) begin
              st    <= IDLE;
              beats <= 5'd0;
            end else if (biu.ack) begin
              st    <= DATA;
              beats <= own_len - 5'd1;
            end else begin
              st    <= DATA;
              beats <= own_len;
            end
          end
        end
        DATA: begin
          if (biu.err) begin
            st     <= IDLE;
            locked <= 1'b0;
            beats  <= 5'd0;
          end else if (biu.ack) begin
            beats <= beats - 5'd1;
            if (beats == 5'd1) st <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pu_riscv_biu_arbiter.sv
// Directed bench for pu_riscv_biu_arbiter; the bench plays both requesters and the bridge.
module tb_pu_riscv_biu_arbiter;

  logic HCLK;
  logic HRESETn;
  int   tests;
  int   fails;

  pu_riscv_biu_arbiter_if #(.XLEN(64), .PLEN(64)) m0 ();
  pu_riscv_biu_arbiter_if #(.XLEN(64), .PLEN(64)) m1 ();
  pu_riscv_biu_arbiter_if #(.XLEN(64), .PLEN(64)) biu ();

  pu_riscv_biu_arbiter #(.XLEN(64), .PLEN(64)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .m0      (m0),
    .m1      (m1),
    .biu     (biu)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Requester must hold stb for the whole address phase.
  always @(negedge HCLK) begin
    if (HRESETn && biu.stb)
      assert (dut.owner ? m1.stb : m0.stb)
      else $error("requester dropped stb during address phase");
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  // Wait for the arbiter's request, accept it, then return nb acks.
  task automatic serve(input int nb, output int gnt, output int acks0, output int acks1,
                       output logic [63:0] adr);
    int to;
    to = 0;
    while (biu.stb !== 1'b1 && to < 20) begin
      cyc();
      to++;
    end
    check_val("grant_wait", 64'(to < 20), 64'd1);
    adr = biu.adri;
    biu.stb_ack = 1'b1;
    #1;
    check_val("one_stb_ack", 64'(m0.stb_ack ^ m1.stb_ack), 64'd1);
    gnt = m1.stb_ack ? 1 : 0;
    cyc();
    biu.stb_ack = 1'b0;
    acks0 = 0;
    acks1 = 0;
    for (int i = 0; i < nb; i++) begin
      biu.ack = 1'b1;
      #1;
      acks0 += int'(m0.ack);
      acks1 += int'(m1.ack);
      cyc();
    end
    biu.ack = 1'b0;
  endtask

  initial begin
    int g;
    int a0;
    int a1;
    logic [63:0] adr;
    tests = 0;
    fails = 0;

    HRESETn = 1'b0;
    {m0.stb, m0.adri, m0.size, m0.btype, m0.prot, m0.lock, m0.we, m0.d} = '0;
    {m1.stb, m1.adri, m1.size, m1.btype, m1.prot, m1.lock, m1.we, m1.d} = '0;
    {biu.stb_ack, biu.d_ack, biu.ack, biu.err, biu.q, biu.adro} = '0;
    cyc();
    biu.ack = 1'b1;
    cyc();
    check_val("rst_biu_stb", 64'(biu.stb), 64'd0);
    check_val("rst_beats", 64'(dut.beats), 64'd0);
    check_val("rst_m0_ack_gated", 64'(m0.ack), 64'd0);
    check_val("rst_m1_ack_gated", 64'(m1.ack), 64'd0);
    biu.ack = 1'b0;

    // Single read on port 0
    HRESETn = 1'b1;
    m0.adri = 64'h1000;
    m0.stb = 1'b1;
    #1;
    check_val("t1_idle_stb", 64'(biu.stb), 64'd0);
    cyc();
    check_val("t1_biu_stb", 64'(biu.stb), 64'd1);
    check_val("t1_biu_adri", biu.adri, 64'h1000);
    biu.stb_ack = 1'b1;
    #1;
    check_val("t1_m0_stb_ack", 64'(m0.stb_ack), 64'd1);
    check_val("t1_m1_stb_ack", 64'(m1.stb_ack), 64'd0);
    cyc();
    biu.stb_ack = 1'b0;
    m0.stb = 1'b0;
    biu.ack = 1'b1;
    biu.q = 64'h1234_5678_9abc_def0;
    #1;
    check_val("t1_data_stb", 64'(biu.stb), 64'd0);
    check_val("t1_m0_ack", 64'(m0.ack), 64'd1);
    check_val("t1_m1_ack", 64'(m1.ack), 64'd0);
    check_val("t1_m0_q", m0.q, 64'h1234_5678_9abc_def0);
    check_val("t1_m1_q_ungated", m1.q, 64'h1234_5678_9abc_def0);
    cyc();
    biu.ack = 1'b1;
    #1;
    check_val("t1_back_idle_ack", 64'(m0.ack), 64'd0);
    check_val("t1_back_idle_beats", 64'(dut.beats), 64'd0);
    biu.ack = 1'b0;
    cyc();
    check_val("t1_stay_idle", 64'(biu.stb), 64'd0);

    // Round robin after reset: 0,1,0,1
    HRESETn = 1'b0;
    cyc();
    HRESETn = 1'b1;
    m1.adri = 64'h2000;
    m0.stb = 1'b1;
    m1.stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      serve(1, g, a0, a1, adr);
      check_val("t2_grant", 64'(g), 64'(i % 2));
      check_val("t2_adri", adr, (i % 2 == 0) ? 64'h1000 : 64'h2000);
      check_val("t2_acks0", 64'(a0), (i % 2 == 0) ? 64'd1 : 64'd0);
      check_val("t2_acks1", 64'(a1), (i % 2 == 0) ? 64'd0 : 64'd1);
    end
    m0.stb = 1'b0;
    m1.stb = 1'b0;

    // Port 1 INCR8 while port 0 waits
    m1.adri = 64'h3000;
    m1.btype = 3'd5;
    m1.stb = 1'b1;
    cyc();
    check_val("t3_biu_adri", biu.adri, 64'h3000);
    m0.stb = 1'b1;
    biu.stb_ack = 1'b1;
    #1;
    check_val("t3_m1_stb_ack", 64'(m1.stb_ack), 64'd1);
    cyc();
    biu.stb_ack = 1'b0;
    m1.stb = 1'b0;
    #1;
    check_val("t3_beats_start", 64'(dut.beats), 64'd8);
    a0 = 0;
    a1 = 0;
    for (int i = 0; i < 8; i++) begin
      biu.ack = 1'b1;
      #1;
      a0 += int'(m0.ack);
      a1 += int'(m1.ack);
      check_val("t3_no_grant_p0", 64'(biu.stb), 64'd0);
      cyc();
      check_val("t3_beats", 64'(dut.beats), 64'(7 - i));
    end
    biu.ack = 1'b0;
    check_val("t3_m1_acks", 64'(a1), 64'd8);
    check_val("t3_m0_acks", 64'(a0), 64'd0);
    cyc();
    check_val("t3_p0_granted", 64'(biu.stb), 64'd1);
    serve(1, g, a0, a1, adr);
    check_val("t3_p0_grant", 64'(g), 64'd0);
    check_val("t3_p0_adri", adr, 64'h1000);
    m0.stb = 1'b0;

    // Locked pair on port 0 while port 1 requests
    m1.btype = 3'd0;
    m0.lock = 1'b1;
    m0.stb = 1'b1;
    serve(1, g, a0, a1, adr);
    check_val("t4_lock_first", 64'(g), 64'd0);
    m0.lock = 1'b0;
    m1.stb = 1'b1;
    serve(1, g, a0, a1, adr);
    check_val("t4_lock_second", 64'(g), 64'd0);
    serve(1, g, a0, a1, adr);
    check_val("t4_after_unlock", 64'(g), 64'd1);
    check_val("t4_after_unlock_ack", 64'(a1), 64'd1);
    m0.stb = 1'b0;
    m1.stb = 1'b0;

    // Error on beat 2 of a port 1 WRAP4
    m1.adri = 64'h4000;
    m1.btype = 3'd2;
    m1.stb = 1'b1;
    cyc();
    m0.stb = 1'b1;
    biu.stb_ack = 1'b1;
    cyc();
    biu.stb_ack = 1'b0;
    m1.stb = 1'b0;
    biu.ack = 1'b1;
    cyc();
    biu.err = 1'b1;
    #1;
    check_val("t5_m1_err", 64'(m1.err), 64'd1);
    check_val("t5_m0_err", 64'(m0.err), 64'd0);
    check_val("t5_m1_ack_fwd", 64'(m1.ack), 64'd1);
    cyc();
    biu.ack = 1'b0;
    biu.err = 1'b0;
    #1;
    check_val("t5_err_one_cycle", 64'(m1.err), 64'd0);
    check_val("t5_idle_stb", 64'(biu.stb), 64'd0);
    check_val("t5_beats_zero", 64'(dut.beats), 64'd0);
    cyc();
    check_val("t5_p0_next", 64'(biu.stb), 64'd1);
    check_val("t5_p0_adri", biu.adri, 64'h1000);

    // Reset in the middle of a port 0 INCR16 write
    m0.btype = 3'd7;
    m0.we = 1'b1;
    m0.d = 64'hCAFE_F00D;
    biu.stb_ack = 1'b1;
    cyc();
    biu.stb_ack = 1'b0;
    m0.stb = 1'b0;
    #1;
    check_val("t6_beats16", 64'(dut.beats), 64'd16);
    check_val("t6_we_follow", 64'(biu.we), 64'd1);
    check_val("t6_d_follow", biu.d, 64'hCAFE_F00D);
    biu.ack = 1'b1;
    cyc();
    cyc();
    cyc();
    check_val("t6_beats13", 64'(dut.beats), 64'd13);
    HRESETn = 1'b0;
    cyc();
    check_val("t6_rst_stb", 64'(biu.stb), 64'd0);
    check_val("t6_rst_we", 64'(biu.we), 64'd0);
    check_val("t6_rst_d", biu.d, 64'd0);
    check_val("t6_rst_adri", biu.adri, 64'd0);
    check_val("t6_rst_m0_ack", 64'(m0.ack), 64'd0);
    check_val("t6_rst_m0_err", 64'(m0.err), 64'd0);
    HRESETn = 1'b1;
    biu.ack = 1'b0;
    m0.btype = 3'd0;
    m0.stb = 1'b1;
    m1.stb = 1'b1;
    cyc();
    biu.stb_ack = 1'b1;
    #1;
    check_val("t6_tie_p0", 64'(m0.stb_ack), 64'd1);
    check_val("t6_tie_not_p1", 64'(m1.stb_ack), 64'd0);
    cyc();
    biu.stb_ack = 1'b0;
    m0.stb = 1'b0;
    m1.stb = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
